regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
// - Parametrised integer register file for the pipelined core: NUM_READ read ports, one write port,
//   write-to-read bypass, optional registered reads, per-register pending (scoreboard) tracking.
// - Sits between decode (read/issue) and writeback; oPending drives the hazard/stall unit.
// - After reset a clear sequencer zeroes the array one entry per cycle; oReady gates the pipeline.
// PARAMETERS
// - ADDRESS_WIDTH   5      register index width; depth = 2**ADDRESS_WIDTH
// - DATA_WIDTH      32     register width
// - NUM_READ        2      number of read ports, 1..4
// - READ_REGISTERED 0      0: combinational read; 1: read data registered on posedge iClk (1-cycle latency)
// - PROBE_ADDR      10     register exposed on oProbe (a0)
// PORTS
// - iClk           in   1                     clock; all state on posedge
// - iRstN          in   1                     asynchronous, active-low reset
// - iWriteEn       in   1                     writeback enable
// - iWriteAddress  in   ADDRESS_WIDTH         writeback destination
// - iDataIn        in   DATA_WIDTH            writeback data
// - iIssueEn       in   1                     an instruction writing iIssueAddress has issued
// - iIssueAddress  in   ADDRESS_WIDTH         destination being marked pending
// - iReadAddress   in   NUM_READ*ADDRESS_WIDTH packed read addresses, port i at [i*AW +: AW]
// - oRegData       out  NUM_READ*DATA_WIDTH    packed read data
// - oPending       out  NUM_READ               port i source register awaiting writeback
// - oProbe         out  DATA_WIDTH            stored value of PROBE_ADDR (no bypass)
// - oReady         out  1                     clear sequence complete
// BEHAVIOUR
// - Reset (iRstN=0, async): FSM->CLEAR, clear counter=0, all busy bits=0, oReady=0, registered
//   oRegData=0; oPending=0, oProbe=0 while in CLEAR.
// - CLEAR: each cycle write 0 to entry[counter], counter++; at counter==2**AW-1 go READY next cycle
//   (2**AW cycles total, 32 at default). Writes/issues ignored; oRegData reads 0.
// - READY: oReady=1; terminal state until next reset. Reset mid-CLEAR restarts from entry 0.
// - Register 0: reads 0 always; writes to 0 dropped; issue to 0 ignored (never pending).
// - Write: iWriteEn & addr!=0 & READY -> entry updated at posedge; busy[addr] cleared unless
//   same-cycle issue to same addr (issue wins, busy stays 1).
// - Writeback to a non-busy register is legal: data written, busy unchanged (0).
// - Issue: iIssueEn & addr!=0 & READY -> busy[addr]=1 at posedge.
// - Bypass: read addr==iWriteAddress, iWriteEn, addr!=0 -> port returns iDataIn same cycle
//   (READ_REGISTERED=1: captured value is iDataIn). Every port bypasses independently.
// - oPending[i] (combinational, both modes, refers to current address):
//   busy[a] & ~(iWriteEn & iWriteAddress==a), OR (iIssueEn & iIssueAddress==a & a!=0).
// - READ_REGISTERED=1: oRegData[i] valid the cycle after the address is presented; holds otherwise.
// - oProbe reflects stored array only; updates the cycle after a write to PROBE_ADDR.
// STRUCTURE
// - Package regfile_pkg: typedef enum logic {RF_CLEAR, RF_READY} rf_state_t; localparam ZERO_REG=0.
// - Sub-module rf_scoreboard: busy-bit vector, set/clear logic, per-port oPending.
// - Top: storage array, clear FSM + counter, read mux/bypass generate loop per port.
// TESTING
// - Reset then idle: oReady=0 for 32 cycles, 1 on cycle 33; all 32 regs read 0; oProbe=0.
// - Write x5=0xDEADBEEF, read x5 on port0 and port1 same cycle -> both 0xDEADBEEF (bypass), next cycle from array.
// - Write x0=0x1234, issue x0 -> reads of x0 give 0, oPending=0.
// - Issue x7; next cycle read x7 -> oPending=1; writeback x7=0x55 -> same cycle oPending=0, data 0x55.
// - Same cycle issue x7 and writeback x7=0x66 -> data 0x66 forwarded, oPending=1 and remains 1 after.
// - Write x10=0xA5A5A5A5, pull iRstN low mid-CLEAR of a second reset -> oReady=0, sequence restarts, x10 reads 0.
// - READ_REGISTERED=1 build: address x3 at cycle n -> data at n+1; repeat directed tests above.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file with pending-writeback scoreboard.
package regfile_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue and cleared on writeback.
// Produces the per-read-port pending flags that feed the hazard/stall unit.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_READ      = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ready,
    input  logic                              write_en,
    input  logic [ADDRESS_WIDTH-1:0]          write_addr,
    input  logic                              issue_en,
    input  logic [ADDRESS_WIDTH-1:0]          issue_addr,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] read_addr,
    output logic [NUM_READ-1:0]               pending
);

    localparam int                     DEPTH     = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic             wr_ok, iss_ok;

    // NOTE: every signal gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        busy_d = busy_q;
        wr_ok  = ready && write_en && (write_addr != ZERO_ADDR);
        iss_ok = ready && issue_en && (issue_addr != ZERO_ADDR);
        if (wr_ok)  busy_d[write_addr] = 1'b0;
        // Applied after the clear so a same-cycle issue to the same register wins.
        if (iss_ok) busy_d[issue_addr] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignment under an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        logic [ADDRESS_WIDTH-1:0] addr;
        assign addr       = read_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign pending[i] = ready &
                            ((busy_q[addr] & ~(write_en & (write_addr == addr))) |
                             (issue_en & (issue_addr == addr) & (addr != ZERO_ADDR)));
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file: NUM_READ bypassed read ports, one write port, optional registered
// reads, post-reset clear sequencer and per-register pending tracking.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 5,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_READ        = 2,
    parameter int READ_REGISTERED = 0,
    parameter int PROBE_ADDR      = 10
) (
    input  logic                              iClk,
    input  logic                              iRstN,
    input  logic                              iWriteEn,
    input  logic [ADDRESS_WIDTH-1:0]          iWriteAddress,
    input  logic [DATA_WIDTH-1:0]             iDataIn,
    input  logic                              iIssueEn,
    input  logic [ADDRESS_WIDTH-1:0]          iIssueAddress,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] iReadAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0]    oRegData,
    output logic [NUM_READ-1:0]               oPending,
    output logic [DATA_WIDTH-1:0]             oProbe,
    output logic                              oReady
);

    localparam int                       DEPTH     = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(ZERO_REG);
    localparam logic [ADDRESS_WIDTH-1:0] PROBE_IDX = ADDRESS_WIDTH'(PROBE_ADDR);

    rf_state_t                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                     ready;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

    assign ready  = (state_q == RF_READY);
    assign oReady = ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = iWriteAddress;
        mem_wdata = iDataIn;
        case (state_q)
            RF_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + ADDRESS_WIDTH'(1);
                if (clr_cnt_q == '1) state_d = RF_READY;
            end
            RF_READY: mem_we = iWriteEn && (iWriteAddress != ZERO_ADDR);
            default:  state_d = RF_CLEAR;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // NOTE: the array has no reset; the clear sequencer zeroes it and outputs are masked until then.
    always_ff @(posedge iClk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign oProbe = ready ? mem_q[PROBE_IDX] : '0;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDRESS_WIDTH-1:0] raddr;
        logic                     bypass;
        logic [DATA_WIDTH-1:0]    rdata_d;

        assign raddr  = iReadAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign bypass = ready && iWriteEn && (iWriteAddress == raddr) && (raddr != ZERO_ADDR);

        always_comb begin
            rdata_d = mem_q[raddr];
            if (!ready || raddr == ZERO_ADDR) rdata_d = '0;
            else if (bypass)                  rdata_d = iDataIn;
        end

        if (READ_REGISTERED != 0) begin : g_registered
            logic [DATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge iClk or negedge iRstN) begin
                if (!iRstN) rdata_q <= '0;
                else        rdata_q <= rdata_d;
            end
            assign oRegData[i*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
        end else begin : g_comb
            assign oRegData[i*DATA_WIDTH +: DATA_WIDTH] = rdata_d;
        end
    end

    rf_scoreboard #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .NUM_READ     (NUM_READ)
    ) u_scoreboard (
        .clk       (iClk),
        .rst_n     (iRstN),
        .ready     (ready),
        .write_en  (iWriteEn),
        .write_addr(iWriteAddress),
        .issue_en  (iIssueEn),
        .issue_addr(iIssueAddress),
        .read_addr (iReadAddress),
        .pending   (oPending)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a combinational-read and a registered-read instance share one stimulus stream.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, ie;
    logic [4:0]  wa, ia;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [63:0] rdata_c, rdata_r;
    logic [1:0]  pend_c, pend_r;
    logic [31:0] probe_c, probe_r;
    logic        ready_c, ready_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .READ_REGISTERED(0), .PROBE_ADDR(10)
    ) dut_c (
        .iClk(clk), .iRstN(rst_n), .iWriteEn(we), .iWriteAddress(wa), .iDataIn(wd),
        .iIssueEn(ie), .iIssueAddress(ia), .iReadAddress(ra),
        .oRegData(rdata_c), .oPending(pend_c), .oProbe(probe_c), .oReady(ready_c)
    );

    regfile_scoreboard #(
        .ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .READ_REGISTERED(1), .PROBE_ADDR(10)
    ) dut_r (
        .iClk(clk), .iRstN(rst_n), .iWriteEn(we), .iWriteAddress(wa), .iDataIn(wd),
        .iIssueEn(ie), .iIssueAddress(ia), .iReadAddress(ra),
        .oRegData(rdata_r), .oPending(pend_r), .oProbe(probe_r), .oReady(ready_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w_en, input logic [4:0] w_a, input logic [31:0] w_d,
                         input logic i_en, input logic [4:0] i_a,
                         input logic [4:0] r0, input logic [4:0] r1);
        we = w_en; wa = w_a; wd = w_d; ie = i_en; ia = i_a;
        ra = {r1, r0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #11;
        check("reset_ready",      ready_c,         0);
        check("reset_rdata_c",    rdata_c[31:0],   0);
        check("reset_pending",    32'(pend_c),     0);
        check("reset_probe",      probe_c,         0);
        check("reset_rdata_r",    rdata_r[31:0],   0);

        // First clear sequence: ready must rise exactly on the 32nd clock.
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            check($sformatf("clear_ready_c%0d", i), ready_c, (i == 32) ? 32'd1 : 32'd0);
            if (i == 20) begin
                drive(1, 7, 32'hFFFF_FFFF, 1, 7, 7, 7);
                check("clear_write_ignored", rdata_c[31:0], 0);
                check("clear_issue_ignored", 32'(pend_c), 0);
            end
            if (i == 21) drive(0, 0, 0, 0, 0, 0, 0);
        end
        check("clear_ready_r", ready_r, 1);
        check("ready_probe",   probe_c, 0);

        for (int r = 0; r < 32; r++) begin
            drive(0, 0, 0, 0, 0, 5'(r), 5'(31 - r));
            check($sformatf("init_p0_x%0d", r), rdata_c[31:0],  0);
            check($sformatf("init_p1_x%0d", 31 - r), rdata_c[63:32], 0);
            check($sformatf("init_pend_x%0d", r), 32'(pend_c), 0);
        end

        // Write x5 with both ports reading it: bypass, then array.
        drive(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 5);
        check("byp_p0", rdata_c[31:0],  32'hDEAD_BEEF);
        check("byp_p1", rdata_c[63:32], 32'hDEAD_BEEF);
        tick();
        drive(0, 0, 0, 0, 0, 5, 5);
        check("arr_p0",     rdata_c[31:0],  32'hDEAD_BEEF);
        check("arr_p1",     rdata_c[63:32], 32'hDEAD_BEEF);
        check("reg_byp_p0", rdata_r[31:0],  32'hDEAD_BEEF);
        check("reg_byp_p1", rdata_r[63:32], 32'hDEAD_BEEF);

        // x0 is hardwired: write and issue are dropped.
        drive(1, 0, 32'h0000_1234, 1, 0, 0, 0);
        check("x0_byp",  rdata_c[31:0], 0);
        check("x0_pend", 32'(pend_c),   0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("x0_arr",      rdata_c[31:0], 0);
        check("x0_pend_aft", 32'(pend_c),   0);
        check("x0_reg",      rdata_r[31:0], 0);

        // Issue x7, later writeback clears pending.
        drive(0, 0, 0, 1, 7, 7, 0);
        check("iss7_same_cycle", 32'(pend_c), 32'b01);
        tick();
        drive(0, 0, 0, 0, 0, 7, 0);
        check("iss7_busy",   32'(pend_c), 32'b01);
        check("iss7_busy_r", 32'(pend_r), 32'b01);
        drive(1, 7, 32'h55, 0, 0, 7, 0);
        check("wb7_pend", 32'(pend_c),   0);
        check("wb7_data", rdata_c[31:0], 32'h55);
        tick();
        drive(0, 0, 0, 0, 0, 7, 0);
        check("wb7_pend_aft", 32'(pend_c),   0);
        check("wb7_arr",      rdata_c[31:0], 32'h55);
        check("wb7_reg",      rdata_r[31:0], 32'h55);

        // Same-cycle issue and writeback: data forwarded, issue keeps the register busy.
        drive(1, 7, 32'h66, 1, 7, 7, 7);
        check("iw7_p0",   rdata_c[31:0],  32'h66);
        check("iw7_p1",   rdata_c[63:32], 32'h66);
        check("iw7_pend", 32'(pend_c),    32'b11);
        tick();
        drive(0, 0, 0, 0, 0, 7, 7);
        check("iw7_pend_aft", 32'(pend_c),   32'b11);
        check("iw7_arr",      rdata_c[31:0], 32'h66);

        // Probe shows stored value only.
        drive(1, 10, 32'hA5A5_A5A5, 0, 0, 10, 0);
        check("probe_no_byp", probe_c,       0);
        check("x10_byp",      rdata_c[31:0], 32'hA5A5_A5A5);
        tick();
        drive(0, 0, 0, 0, 0, 10, 0);
        check("probe_upd",   probe_c, 32'hA5A5_A5A5);
        check("probe_upd_r", probe_r, 32'hA5A5_A5A5);

        // Registered read latency on x3.
        drive(1, 3, 32'h3333_3333, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 3, 0);
        check("reg_lat_hold", rdata_r[31:0], 0);
        check("reg_lat_comb", rdata_c[31:0], 32'h3333_3333);
        tick();
        check("reg_lat_n1",   rdata_r[31:0], 32'h3333_3333);

        // Second reset, interrupted mid-clear by a third.
        rst_n = 1'b0;
        #1;
        check("rst2_ready",   ready_c,       0);
        check("rst2_rdata_r", rdata_r[31:0], 0);
        check("rst2_probe",   probe_c,       0);
        drive(0, 0, 0, 0, 0, 10, 7);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) tick();
        check("rst2_mid_ready", ready_c, 0);
        rst_n = 1'b0;
        #1;
        check("rst3_ready", ready_c, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i >= 31)
                check($sformatf("rst3_ready_c%0d", i), ready_c, (i == 32) ? 32'd1 : 32'd0);
        end
        check("rst3_x10",    rdata_c[31:0],  0);
        check("rst3_x7",     rdata_c[63:32], 0);
        check("rst3_pend",   32'(pend_c),    0);
        check("rst3_probe",  probe_c,        0);
        tick();
        check("rst3_x10_r",  rdata_r[31:0],  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
